// File: rtl/line_fifo_pkg.sv
// line_fifo_pkg: default sizing constants and a constant-foldable clog2 for line_fifo
package line_fifo_pkg;
  localparam int LINE_FIFO_DATA_W = 16;
  localparam int LINE_FIFO_DEPTH = 400;
  function automatic int line_fifo_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/line_fifo_ram.sv
// line_fifo_ram: simple dual-port storage, one write port and one registered read port
module line_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 400,
  parameter int PTR_W = 9
) (
  input  logic              half_clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge half_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // A same-edge write to the read address returns the old word (read-before-write).
  always_ff @(posedge half_clk or posedge rst)
    if (rst) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/line_fifo.sv
// line_fifo: parametrised single-clock FIFO with registered flags and synchronous flush.
// Define LINE_FIFO_ERR_EN to build sticky overflow/underflow flags; otherwise they read 0.
module line_fifo
  import line_fifo_pkg::*;
#(
  parameter int DATA_W = LINE_FIFO_DATA_W,
  parameter int DEPTH = LINE_FIFO_DEPTH,
  parameter int AFULL_TH = DEPTH - 16,
  parameter int AEMPTY_TH = 16
) (
  input  logic                                 half_clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 wr_en,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic                                 rd_en,
  output logic [DATA_W-1:0]                    rd_data,
  output logic                                 rd_valid,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 almost_empty,
  output logic                                 almost_full,
  output logic [line_fifo_clog2(DEPTH+1)-1:0]  count,
  output logic                                 overflow,
  output logic                                 underflow
);
  localparam int CNT_W = line_fifo_clog2(DEPTH + 1);
  localparam int PTR_W = line_fifo_clog2(DEPTH);
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_inc, w_rd_ptr_inc;
  logic [CNT_W-1:0] r_count, w_cnt_nxt;
  logic r_empty, r_full, r_aempty, r_afull, r_rd_valid;
  logic w_rd_acc, w_wr_acc;
  assign w_rd_acc = rd_en && !r_empty && !clr;
  assign w_wr_acc = wr_en && (!r_full || w_rd_acc) && !clr;
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_cnt_nxt = clr ? '0 : r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
  // Flags come from the next count so they are registered, never combinational from requests.
  always_ff @(posedge half_clk or posedge rst)
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_aempty   <= 1'b1;
      r_afull    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= clr ? '0 : w_wr_acc ? w_wr_ptr_inc : r_wr_ptr;
      r_rd_ptr   <= clr ? '0 : w_rd_acc ? w_rd_ptr_inc : r_rd_ptr;
      r_count    <= w_cnt_nxt;
      r_empty    <= w_cnt_nxt == '0;
      r_full     <= w_cnt_nxt == CNT_W'(DEPTH);
      r_aempty   <= int'(w_cnt_nxt) <= AEMPTY_TH;
      r_afull    <= !clr && int'(w_cnt_nxt) >= AFULL_TH;
      r_rd_valid <= w_rd_acc;
    end
  line_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .half_clk (half_clk),
    .rst      (rst),
    .i_we     (w_wr_acc),
    .i_waddr  (r_wr_ptr),
    .i_wdata  (wr_data),
    .i_re     (w_rd_acc),
    .i_raddr  (r_rd_ptr),
    .o_rdata  (rd_data)
  );
`ifdef LINE_FIFO_ERR_EN
  logic r_ovf, r_unf;
  always_ff @(posedge half_clk or posedge rst)
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= !clr && (r_ovf || (wr_en && !w_wr_acc));
      r_unf <= !clr && (r_unf || (rd_en && r_empty));
    end
  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
  assign rd_valid     = r_rd_valid;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_aempty;
  assign almost_full  = r_afull;
  assign count        = r_count;
endmodule
